yarvi_bus_target: RTL and testbench



---
 rtl/yarvi_bus_pkg.sv | 23 ++
 rtl/yarvi_bus_ram.sv | 30 +++
 rtl/yarvi_bus_target.sv | 129 ++++++++++++
 tb/tb_yarvi_bus_target.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/yarvi_bus_pkg.sv
// Shared definitions for the htif bus target: MMIO register map and FSM encoding.
package yarvi_bus_pkg;

  localparam logic [31:0] CORE_RESET_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] CYCLE_ADDR      = 32'hFFFF_FFF8;
  localparam logic [31:0] ERR_ADDR        = 32'hFFFF_FFF4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } state_e;

  // Compare two byte addresses at word granularity (bits [1:0] are don't-care).
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

  function automatic logic [31:0] bit_word(input logic b);
    return {31'b0, b};
  endfunction

endpackage

// File: rtl/yarvi_bus_ram.sv
// Single-port word RAM, synchronous read, write-first; read port only updates when en is high.
module yarvi_bus_ram #(
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(2**ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata_q   <= wdata;
      end else begin
        rdata_q   <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/yarvi_bus_target.sv
// Responder for the htif bus: word RAM at the bottom of the map, MMIO page at the top.
//   state | meaning
//   IDLE  | no read in flight, ready for a request
//   RD    | read accepted last cycle, RAM output valid, ready low
//   RSP   | bus_res_valid high, a new request may be accepted
module yarvi_bus_target
  import yarvi_bus_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter bit CORE_RESET_INIT = 1'b1,
  parameter     INIT_FILE       = ""
) (
  input  logic        clock,
  input  logic        reset,
  output logic        bus_req_ready,
  input  logic        bus_req_read,
  input  logic        bus_req_write,
  input  logic [31:0] bus_req_address,
  input  logic [31:0] bus_req_data,
  output logic        bus_res_valid,
  output logic [31:0] bus_res_data,
  output logic        core_reset
);

  state_e      state_q, state_d;
  logic        core_reset_q, core_reset_d;
  logic        err_q, err_d;
  logic [31:0] cycle_q, cycle_d;
  logic        sel_ram_q, sel_ram_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;

  logic        accept;
  logic        ram_hit, cr_hit, cyc_hit, err_hit, bad_access;
  logic [31:0] ram_rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus_req_address[1:0];

  assign bus_req_ready = !reset && (state_q != RD);
  assign accept        = bus_req_ready && (bus_req_read || bus_req_write);

  assign ram_hit    = (bus_req_address[31:ADDR_W+2] == '0);
  assign cr_hit     = word_match(bus_req_address, CORE_RESET_ADDR);
  assign cyc_hit    = word_match(bus_req_address, CYCLE_ADDR);
  assign err_hit    = word_match(bus_req_address, ERR_ADDR);
  // The cycle counter is read-only, so writing it counts as a decode error.
  assign bad_access = !(ram_hit || cr_hit || err_hit || (cyc_hit && !bus_req_write));

  yarvi_bus_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clock (clock),
    .en    (accept && ram_hit),
    .we    (accept && ram_hit && bus_req_write),
    .addr  (bus_req_address[ADDR_W+1:2]),
    .wdata (bus_req_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    core_reset_d = core_reset_q;
    err_d        = err_q;
    cycle_d      = cycle_q + 32'd1;
    sel_ram_d    = sel_ram_q;
    mmio_rdata_d = mmio_rdata_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;

    case (state_q)
      RD: begin
        state_d     = RSP;
        res_valid_d = 1'b1;
        res_data_d  = sel_ram_q ? ram_rdata : mmio_rdata_q;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (bus_req_write && cr_hit)  core_reset_d = bus_req_data[0];
      if (bus_req_write && err_hit) err_d = 1'b0;
      if (bad_access)               err_d = 1'b1;

      if (bus_req_read) begin
        state_d   = RD;
        sel_ram_d = ram_hit;
        // Snapshot the MMIO value now; a combined write returns the value just written.
        if (cr_hit)
          mmio_rdata_d = bit_word(bus_req_write ? bus_req_data[0] : core_reset_q);
        else if (cyc_hit && !bus_req_write)
          mmio_rdata_d = cycle_q;
        else if (err_hit)
          mmio_rdata_d = bit_word(bus_req_write ? 1'b0 : err_q);
        else
          mmio_rdata_d = 32'h0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      core_reset_q <= CORE_RESET_INIT;
      err_q        <= 1'b0;
      cycle_q      <= 32'h0;
      sel_ram_q    <= 1'b0;
      mmio_rdata_q <= 32'h0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      err_q        <= err_d;
      cycle_q      <= cycle_d;
      sel_ram_q    <= sel_ram_d;
      mmio_rdata_q <= mmio_rdata_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
    end
  end

  assign bus_res_valid = res_valid_q;
  assign bus_res_data  = res_data_q;
  assign core_reset    = core_reset_q;

endmodule

// File: tb/tb_yarvi_bus_target.sv
// Scoreboard bench for yarvi_bus_target: directed requests push expected read data, a monitor checks responses.
module tb_yarvi_bus_target;

  logic        clock = 1'b0;
  logic        reset;
  logic        bus_req_ready;
  logic        bus_req_read;
  logic        bus_req_write;
  logic [31:0] bus_req_address;
  logic [31:0] bus_req_data;
  logic        bus_res_valid;
  logic [31:0] bus_res_data;
  logic        core_reset;

  int errors = 0;
  int checks = 0;
  int tb_cyc = 0;
  logic [31:0] model_cyc = 32'h0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q [$];

  yarvi_bus_target #(
    .ADDR_W          (10),
    .CORE_RESET_INIT (1'b1),
    .INIT_FILE       ("")
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus_req_ready   (bus_req_ready),
    .bus_req_read    (bus_req_read),
    .bus_req_write   (bus_req_write),
    .bus_req_address (bus_req_address),
    .bus_req_data    (bus_req_data),
    .bus_res_valid   (bus_res_valid),
    .bus_res_data    (bus_res_data),
    .core_reset      (core_reset)
  );

  always #5 clock = ~clock;

  // Reference cycle counter: cleared by reset, +1 per clock otherwise.
  always @(posedge clock) begin
    tb_cyc <= tb_cyc + 1;
    if (reset) model_cyc <= 32'h0;
    else       model_cyc <= model_cyc + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (bus_res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_response", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", bus_res_data, e.data);
        check("res_latency", tb_cyc - e.cyc, 32'd2);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rexp, input bit push = 1'b1);
    int n = 0;
    exp_t e;
    bus_req_read    = rd;
    bus_req_write   = wr;
    bus_req_address = addr;
    bus_req_data    = wdata;
    while (!bus_req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus_req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (rd && push) begin
      e.data = rexp;
      e.cyc  = tb_cyc;
      exp_q.push_back(e);
    end
    @(negedge clock);
    bus_req_read  = 1'b0;
    bus_req_write = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    int t0;
    reset           = 1'b1;
    bus_req_read    = 1'b0;
    bus_req_write   = 1'b0;
    bus_req_address = 32'h0;
    bus_req_data    = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_ready",      bus_req_ready, 32'd0);
    check("rst_res_valid",  bus_res_valid, 32'd0);
    check("rst_res_data",   bus_res_data,  32'd0);
    check("rst_core_reset", core_reset,    32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", bus_req_ready, 32'd1);
    check("core_reset_init", core_reset, 32'd1);

    // RAM write then read, and write-through readback
    issue(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678);
    drain();
    issue(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'hCAFE_F00D);
    issue(1'b0, 1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0);
    issue(1'b1, 1'b0, 32'h0000_0FFF, 32'h0,         32'hDEAD_BEEF);
    drain();

    // core_reset control
    issue(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);
    check("core_reset_cleared", core_reset, 32'd0);
    issue(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    drain();
    issue(1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h1);
    check("core_reset_set", core_reset, 32'd1);
    drain();

    // cycle counter: two reads 10 cycles apart, then wrap
    issue(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, model_cyc);
    t0 = tb_cyc - 1;
    while (tb_cyc < t0 + 10) @(negedge clock);
    issue(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, model_cyc);
    drain();
    force dut.cycle_q = 32'hFFFF_FFFF;
    issue(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFFF);
    release dut.cycle_q;
    issue(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0);
    drain();

    // decode errors and the sticky err flag
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0, 32'h1);
    issue(1'b0, 1'b1, 32'hFFFF_FFF4, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0, 32'h0);
    issue(1'b0, 1'b1, 32'hFFFF_FFF8, 32'h5555_5555, 32'h0);
    issue(1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0, 32'h1);
    issue(1'b1, 1'b1, 32'hFFFF_FFF4, 32'h0, 32'h0);
    issue(1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0, 32'h1);
    issue(1'b0, 1'b1, 32'hFFFF_FFF4, 32'h0, 32'h0);
    drain();

    // back-to-back reads; the write just past the RAM must not alias word 0
    issue(1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'h0);
    issue(1'b0, 1'b1, 32'h0000_0004, 32'h5A5A_0002, 32'h0);
    issue(1'b0, 1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 32'h0);
    issue(1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_0001);
    check("b2b_ready_low_1", bus_req_ready, 32'd0);
    issue(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h5A5A_0002);
    check("b2b_ready_low_2", bus_req_ready, 32'd0);
    drain();
    issue(1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0, 32'h1);
    drain();

    // reset during RD drops the response
    issue(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready_after_rd_reset", bus_req_ready, 32'd1);
    check("core_reset_reinit", core_reset, 32'd1);
    repeat (4) @(negedge clock);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678);
    issue(1'b1, 1'b0, 32'hFFFF_FFF4, 32'h0, 32'h0);
    drain();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
